// File: rtl/count_ctrl_if.sv
// Command and status bundle for count_ctrl: the controller side drives the commands
// and limit, and count_ctrl drives back the counter, display and status flags.
interface count_ctrl_if;
    logic        start_stop;
    logic        lap;
    logic        clr;
    logic [15:0] limit;
    logic [15:0] count;
    logic [15:0] display;
    logic        tick;
    logic        running;
    logic        done;

    modport master (
        output start_stop, lap, clr, limit,
        input  count, display, tick, running, done
    );

    modport slave (
        input  start_stop, lap, clr, limit,
        output count, display, tick, running, done
    );
endinterface

// File: rtl/count_ctrl.sv
// Prescaled stopwatch-style counter with pause, lap freeze and terminal limit.
// Define COUNT_CTRL_AUTORELOAD_EN to wrap to zero at the limit instead of stopping.
module count_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic      clk,
    input  logic      reset,
    count_ctrl_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   count_q;
    logic [15:0]   lap_q;
    logic [PW-1:0] presc;
    logic          frozen;
    logic          done_q;
    logic          tick_q;
    logic          ss_prev;
    logic          lap_prev;
    logic          clr_prev;

    logic          ss_ev;
    logic          lap_ev;
    logic          clr_ev;
    logic [15:0]   count_next;

    assign ss_ev      = bus.start_stop & ~ss_prev;
    assign lap_ev     = bus.lap & ~lap_prev;
    assign clr_ev     = bus.clr & ~clr_prev;
    assign count_next = count_q + 16'd1;

    // Command priority is clr, then start_stop, then lap; losers in the same cycle are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count_q  <= '0;
            lap_q    <= '0;
            presc    <= '0;
            frozen   <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
            ss_prev  <= bus.start_stop;
            lap_prev <= bus.lap;
            clr_prev <= bus.clr;
        end else begin
            ss_prev  <= bus.start_stop;
            lap_prev <= bus.lap;
            clr_prev <= bus.clr;
            tick_q   <= 1'b0;
`ifdef COUNT_CTRL_AUTORELOAD_EN
            done_q   <= 1'b0;
`endif
            if (clr_ev) begin
                state   <= IDLE;
                count_q <= '0;
                presc   <= '0;
                frozen  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_ev) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end
                    RUN: begin
                        if (ss_ev) begin
                            state <= PAUSE;
                        end else begin
                            if (lap_ev) begin
                                frozen <= ~frozen;
                                if (!frozen) lap_q <= count_q;
                            end
                            if (presc == PRESC_MAX) begin
                                presc  <= '0;
                                tick_q <= 1'b1;
                                if (count_next == bus.limit) begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
                                    count_q <= '0;
                                    done_q  <= 1'b1;
`else
                                    count_q <= bus.limit;
                                    done_q  <= 1'b1;
                                    state   <= DONE;
`endif
                                end else begin
                                    count_q <= count_next;
                                end
                            end else begin
                                presc <= presc + 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (ss_ev) begin
                            state <= RUN;
                        end else if (lap_ev) begin
                            frozen <= ~frozen;
                            if (!frozen) lap_q <= count_q;
                        end
                    end
                    default: begin
                        state <= DONE;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.display = frozen ? lap_q : count_q;
    assign bus.tick    = tick_q;
    assign bus.running = (state == RUN);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: one instance with PRESCALE=4 and one with PRESCALE=1.
// Building with COUNT_CTRL_AUTORELOAD_EN selects the autoreload sequence instead.
module tb_count_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    count_ctrl_if a4 ();
    count_ctrl_if a1 ();

    count_ctrl #(.PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(a4.slave));
    count_ctrl #(.PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(a1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        a4.start_stop = 1'b0; a4.lap = 1'b0; a4.clr = 1'b0; a4.limit = 16'd5;
        a1.start_stop = 1'b0; a1.lap = 1'b0; a1.clr = 1'b0; a1.limit = 16'd0;
        applyStimulus(2);
        reset = 1'b0;

        checkOutput("rst_count",   a4.count,   0);
        checkOutput("rst_display", a4.display, 0);
        checkOutput("rst_running", a4.running, 0);
        checkOutput("rst_done",    a4.done,    0);
        checkOutput("rst_tick",    a4.tick,    0);
        applyStimulus(1);

`ifdef COUNT_CTRL_AUTORELOAD_EN
        begin
            logic [15:0] exp_cnt [6];
            logic        exp_done [6];
            exp_cnt  = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
            exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            a1.limit = 16'd3;
            a1.start_stop = 1'b1;
            applyStimulus(1);
            a1.start_stop = 1'b0;
            checkOutput("ar_start_running", a1.running, 1);
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1);
                checkOutput($sformatf("ar_count_%0d", i), a1.count, exp_cnt[i]);
                checkOutput($sformatf("ar_done_%0d", i), a1.done, exp_done[i]);
                checkOutput($sformatf("ar_running_%0d", i), a1.running, 1);
            end
        end
`else
        // Basic run to the limit.
        a4.start_stop = 1'b1;
        applyStimulus(1);
        a4.start_stop = 1'b0;
        checkOutput("a_running", a4.running, 1);
        checkOutput("a_count0",  a4.count,   0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(3);
            checkOutput($sformatf("a_notick_%0d", k), a4.tick, 0);
            applyStimulus(1);
            checkOutput($sformatf("a_tick_%0d", k), a4.tick, 1);
            checkOutput($sformatf("a_count_%0d", k), a4.count, k);
        end
        checkOutput("a_running_end", a4.running, 0);
        checkOutput("a_done",        a4.done,    1);
        a4.start_stop = 1'b1;
        applyStimulus(1);
        a4.start_stop = 1'b0;
        applyStimulus(19);
        checkOutput("a_hold_count", a4.count,   5);
        checkOutput("a_hold_done",  a4.done,    1);
        checkOutput("a_hold_run",   a4.running, 0);
        a4.clr = 1'b1;
        applyStimulus(1);
        a4.clr = 1'b0;
        checkOutput("a_clr_count", a4.count, 0);
        checkOutput("a_clr_done",  a4.done,  0);

        // Pause keeps the partial prescaler count.
        a4.start_stop = 1'b1;
        applyStimulus(1);
        a4.start_stop = 1'b0;
        applyStimulus(6);
        a4.start_stop = 1'b1;
        applyStimulus(1);
        a4.start_stop = 1'b0;
        checkOutput("b_paused",       a4.running, 0);
        checkOutput("b_paused_count", a4.count,   1);
        applyStimulus(10);
        checkOutput("b_hold_count", a4.count, 1);
        a4.start_stop = 1'b1;
        applyStimulus(1);
        a4.start_stop = 1'b0;
        checkOutput("b_resumed", a4.running, 1);
        applyStimulus(1);
        checkOutput("b_tick_early", a4.tick, 0);
        applyStimulus(1);
        checkOutput("b_tick",  a4.tick,  1);
        checkOutput("b_count", a4.count, 2);

        // Lap freeze and unfreeze; limit raised so the run continues.
        a4.limit = 16'd100;
        applyStimulus(4);
        checkOutput("c_count3", a4.count, 3);
        a4.lap = 1'b1;
        applyStimulus(1);
        a4.lap = 1'b0;
        checkOutput("c_frozen_disp", a4.display, 3);
        applyStimulus(15);
        checkOutput("c_count7",      a4.count,   7);
        checkOutput("c_still_disp3", a4.display, 3);
        a4.lap = 1'b1;
        applyStimulus(1);
        a4.lap = 1'b0;
        checkOutput("c_unfrozen_disp", a4.display, 7);
        applyStimulus(2);
        a4.lap = 1'b1;
        applyStimulus(1);
        a4.lap = 1'b0;
        checkOutput("c_lap_tick_count", a4.count,   8);
        checkOutput("c_lap_tick_disp",  a4.display, 7);

        // Simultaneous clr, start_stop and lap while running and frozen.
        a4.clr = 1'b1; a4.start_stop = 1'b1; a4.lap = 1'b1;
        applyStimulus(1);
        a4.clr = 1'b0; a4.start_stop = 1'b0; a4.lap = 1'b0;
        checkOutput("d_running", a4.running, 0);
        checkOutput("d_count",   a4.count,   0);
        checkOutput("d_display", a4.display, 0);
        applyStimulus(5);
        checkOutput("d_idle_count", a4.count,   0);
        checkOutput("d_idle_run",   a4.running, 0);

        // Full 16-bit wrap with limit 0, preceded by a mid-run reset.
        a1.start_stop = 1'b1;
        applyStimulus(1);
        a1.start_stop = 1'b0;
        applyStimulus(16'h1234);
        checkOutput("e_count1234", a1.count, 16'h1234);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("e_rst_count",   a1.count,   0);
        checkOutput("e_rst_running", a1.running, 0);
        checkOutput("e_rst_done",    a1.done,    0);
        applyStimulus(2);
        checkOutput("e_rst_idle", a1.count, 0);
        a1.start_stop = 1'b1;
        applyStimulus(1);
        a1.start_stop = 1'b0;
        applyStimulus(65535);
        checkOutput("e_count_ffff", a1.count,   16'hFFFF);
        checkOutput("e_running",    a1.running, 1);
        checkOutput("e_not_done",   a1.done,    0);
        applyStimulus(1);
        checkOutput("e_wrap_count", a1.count,   0);
        checkOutput("e_wrap_done",  a1.done,    1);
        checkOutput("e_wrap_run",   a1.running, 0);
        checkOutput("e_wrap_tick",  a1.tick,    1);
        applyStimulus(1);
        checkOutput("e_after_tick", a1.tick, 0);
        checkOutput("e_after_done", a1.done, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
